monitor_tx_scheduler: RTL

- Shares the single monitor UART transmitter between NUM_REQ response sources, e.g. the command READ path and asynchronous status reporters.
- Arbitrates round-robin and latches the winner's packet.
- Serialises the packet through the tx byte handshake: command byte, length byte, then payload bytes LSB-first.
- Honours host flow control between bytes, and reports completion or error back to the requester.

---
 rtl/monitor_tx_scheduler_if.sv | 20 ++
 rtl/monitor_tx_scheduler.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/monitor_tx_scheduler_if.sv
// Byte handshake between the tx scheduler and the monitor UART transmitter.
// master: scheduler (tx_write/tx_byte out); slave: transmitter and host flow control.
interface monitor_tx_scheduler_if;
    logic       host_rdy;
    logic       tx_write;
    logic [7:0] tx_byte;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_write, tx_byte,
        input  host_rdy, tx_busy, tx_done, tx_error
    );

    modport slave (
        input  tx_write, tx_byte,
        output host_rdy, tx_busy, tx_done, tx_error
    );
endinterface

// File: rtl/monitor_tx_scheduler.sv
// Round-robin sharing of the monitor UART tx among NUM_REQ packet sources.
// Ports: clk, reset (sync, high); req/req_cmd/req_len/req_data per source;
// grant/done/err back to sources; tx (master) carries the byte handshake.
module monitor_tx_scheduler #(
    parameter int NUM_REQ   = 2,
    parameter int MAX_BYTES = 8,
    parameter int TIMEOUT   = 4096
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [8*NUM_REQ-1:0]           req_cmd,
    input  logic [8*NUM_REQ-1:0]           req_len,
    input  logic [8*MAX_BYTES*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]             grant,
    output logic [NUM_REQ-1:0]             done,
    output logic                           err,
    monitor_tx_scheduler_if.master         tx
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int IW = $clog2(MAX_BYTES + 2);
    localparam int TW = $clog2(TIMEOUT);
    localparam int PB = 8 * MAX_BYTES;
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0] RR_INIT = PW'(NUM_REQ - 1);
    localparam logic [7:0]    MAX_LEN = 8'(MAX_BYTES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [IW-1:0] idx;
    logic [TW-1:0] tmo;
    logic [7:0]    cmd_q;
    logic [7:0]    len_q;
    logic [PB-1:0] data_q;
    logic          trunc;

    logic          found;
    logic [PW-1:0] win;
    logic [7:0]    win_cmd;
    logic [7:0]    win_len;
    logic [PB-1:0] win_data;
    logic [PB-1:0] pay_sh;
    logic [7:0]    seq_byte;
    logic          last;

    // First requester above the last winner, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = rr_ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                win   = PW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign win_cmd  = req_cmd[8*win +: 8];
    assign win_len  = req_len[8*win +: 8];
    assign win_data = req_data[PB*win +: PB];

    // Packet byte idx: 0 = cmd, 1 = len, then payload LSB-first.
    assign pay_sh   = data_q >> (8 * (int'(idx) - 2));
    assign seq_byte = (idx == '0)       ? cmd_q :
                      (idx == IW'(1))   ? len_q : pay_sh[7:0];
    assign last     = (int'(idx) == int'(len_q) + 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            done        <= '0;
            err         <= 1'b0;
            tx.tx_write <= 1'b0;
            tx.tx_byte  <= '0;
            rr_ptr      <= RR_INIT;
            idx         <= '0;
            tmo         <= '0;
            cmd_q       <= '0;
            len_q       <= '0;
            data_q      <= '0;
            trunc       <= 1'b0;
        end else begin
            tx.tx_write <= 1'b0;
            done        <= '0;
            err         <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant  <= NUM_REQ'(1) << win;
                        rr_ptr <= win;
                        cmd_q  <= win_cmd;
                        data_q <= win_data;
                        if (win_len > MAX_LEN) begin
                            len_q <= MAX_LEN;
                            trunc <= 1'b1;
                        end else begin
                            len_q <= win_len;
                            trunc <= 1'b0;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (tx.host_rdy && !tx.tx_busy) begin
                        tx.tx_write <= 1'b1;
                        tx.tx_byte  <= seq_byte;
                        tmo         <= '0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    tmo <= tmo + 1'b1;
                    // Error beats done when both arrive together.
                    if (tx.tx_error) begin
                        done  <= grant;
                        err   <= 1'b1;
                        state <= FINISH;
                    end else if (tx.tx_done) begin
                        if (last) begin
                            done  <= grant;
                            err   <= trunc;
                            state <= FINISH;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ISSUE;
                        end
                    end else if (tmo == T_LAST) begin
                        done  <= grant;
                        err   <= 1'b1;
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    grant <= '0;
                    idx   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
